sb_param_shadow: RTL and testbench

//  Parametrised edge switch block (right + bottom sides) for the routing fabric.

---
 rtl/sb_cfg_pkg.sv | 30 +++
 rtl/sb_cfg_chain.sv | 80 ++++++++
 rtl/sb_param_shadow.sv | 80 ++++++++
 tb/tb_sb_param_shadow.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sb_cfg_pkg                                                           |
// | Shared constants and helper functions for the shadowed switch block. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package sb_cfg_pkg;

   // Mux input slots of a right-track candidate vector
   localparam int SRC_CHANY = 0;
   localparam int SRC_OPIN0 = 1;

   // Bottom-track select value that picks the left inpad
   localparam logic SEL_BOT_INPAD = 1'b1;

   // Ceiling log2, usable in parameter expressions
   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res = res + 1;
      return res;
   endfunction

   // Default track source: (chan_w-2-k) mod chan_w, kept non-negative
   function automatic int src_idx(input int k, input int chan_w);
      return (2 * chan_w - 2 - k) % chan_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sb_cfg_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sb_cfg_chain                                                         |
// | Double-buffered serial configuration chain with bit-count check.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sb_cfg_chain
   import sb_cfg_pkg::*;
#(
   parameter int CFG_BITS = 55,
   parameter int CNT_W    = clog2(CFG_BITS + 2)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ccff_head,
   input  logic                shift_en,
   input  logic                commit,
   output logic [CFG_BITS-1:0] shadow,
   output logic                ccff_tail,
   output logic                cfg_done,
   output logic                cfg_err
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [CFG_BITS-1:0] shift_reg_q, shift_reg_d;
   logic [CFG_BITS-1:0] shadow_q,    shadow_d;
   logic [CNT_W-1:0]    count_q,     count_d;
   logic                done_q,      done_d;
   logic                err_q,       err_d;

   // Next-state: commit takes priority over shift; shift_reg survives a commit for readback
   always_comb begin
      shift_reg_d = shift_reg_q;
      shadow_d    = shadow_q;
      count_d     = count_q;
      done_d      = done_q;
      err_d       = err_q;
      if (commit) begin
         count_d = '0;
         if (count_q == CNT_FULL) begin
            shadow_d = shift_reg_q;
            done_d   = 1'b1;
            err_d    = 1'b0;
         end else begin
            done_d   = 1'b0;
            err_d    = 1'b1;
         end
      end else if (shift_en) begin
         shift_reg_d = {shift_reg_q[CFG_BITS-2:0], ccff_head};
         count_d     = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
         done_d      = 1'b0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_reg_q <= '0;
         shadow_q    <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         shift_reg_q <= shift_reg_d;
         shadow_q    <= shadow_d;
         count_q     <= count_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign shadow    = shadow_q;
   assign ccff_tail = shift_reg_q[CFG_BITS-1];
   assign cfg_done  = done_q;
   assign cfg_err   = err_q;

endmodule
`default_nettype wire

// File: rtl/sb_param_shadow.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sb_param_shadow                                                      |
// | Edge switch block (right + bottom) with glitch-free shadowed config. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sb_param_shadow
   import sb_cfg_pkg::*;
#(
   parameter int CHAN_W    = 11,
   parameter int NUM_OPINS = 8
) (
   input  logic                 prog_clk,
   input  logic                 prog_reset_n,
   input  logic                 ccff_head,
   input  logic                 cfg_shift_en,
   input  logic                 cfg_commit,
   input  logic [CHAN_W-1:0]    chanx_right_in,
   input  logic [CHAN_W-1:0]    chany_bottom_in,
   input  logic [NUM_OPINS-1:0] grid_opin,
   input  logic                 top_inpad,
   input  logic                 left_inpad,
   output logic [CHAN_W-1:0]    chanx_right_out,
   output logic [CHAN_W-1:0]    chany_bottom_out,
   output logic                 ccff_tail,
   output logic                 cfg_done,
   output logic                 cfg_err
);

   localparam int SEL_R    = clog2(NUM_OPINS + 2);
   localparam int CFG_BITS = CHAN_W * SEL_R + CHAN_W;
   localparam int CNT_W    = clog2(CFG_BITS + 2);

   logic [CFG_BITS-1:0] shadow;

   sb_cfg_chain #(
      .CFG_BITS (CFG_BITS),
      .CNT_W    (CNT_W)
   ) u_chain (
      .clk       (prog_clk),
      .rst_n     (prog_reset_n),
      .ccff_head (ccff_head),
      .shift_en  (cfg_shift_en),
      .commit    (cfg_commit),
      .shadow    (shadow),
      .ccff_tail (ccff_tail),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err)
   );

   genvar gi;

   // Right tracks: candidates padded with zeros so out-of-range selects drive 0
   for (gi = 0; gi < CHAN_W; gi++) begin : g_right
      localparam int SRC = src_idx(gi, CHAN_W);
      logic [SEL_R-1:0]      sel;
      logic [(1<<SEL_R)-1:0] cand;

      assign sel = shadow[gi*SEL_R +: SEL_R];

      // Assemble the candidate inputs for this track
      always_comb begin
         cand                          = '0;
         cand[SRC_CHANY]               = chany_bottom_in[SRC];
         cand[SRC_OPIN0 +: NUM_OPINS]  = grid_opin;
         cand[NUM_OPINS+1]             = top_inpad;
      end

      assign chanx_right_out[gi] = cand[sel];
   end

   // Bottom tracks: one select bit each, chanx track or the left inpad
   for (gi = 0; gi < CHAN_W; gi++) begin : g_bottom
      localparam int SRC = src_idx(gi, CHAN_W);
      assign chany_bottom_out[gi] = (shadow[CHAN_W*SEL_R + gi] == SEL_BOT_INPAD) ?
                                    left_inpad : chanx_right_in[SRC];
   end

endmodule
`default_nettype wire

// File: tb/tb_sb_param_shadow.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sb_param_shadow                                                   |
// | Self-checking bench with a behavioural model of the switch block.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_sb_param_shadow;

   localparam int CHAN_W    = 11;
   localparam int NUM_OPINS = 8;
   localparam int SEL_R     = 4;
   localparam int CFG_BITS  = 55;
   localparam int CNT_SAT   = 63;

   logic              prog_clk;
   logic              prog_reset_n;
   logic              ccff_head;
   logic              cfg_shift_en;
   logic              cfg_commit;
   logic [CHAN_W-1:0] chanx_right_in;
   logic [CHAN_W-1:0] chany_bottom_in;
   logic [NUM_OPINS-1:0] grid_opin;
   logic              top_inpad;
   logic              left_inpad;
   logic [CHAN_W-1:0] chanx_right_out;
   logic [CHAN_W-1:0] chany_bottom_out;
   logic              ccff_tail;
   logic              cfg_done;
   logic              cfg_err;

   sb_param_shadow #(
      .CHAN_W    (CHAN_W),
      .NUM_OPINS (NUM_OPINS)
   ) dut (
      .prog_clk         (prog_clk),
      .prog_reset_n     (prog_reset_n),
      .ccff_head        (ccff_head),
      .cfg_shift_en     (cfg_shift_en),
      .cfg_commit       (cfg_commit),
      .chanx_right_in   (chanx_right_in),
      .chany_bottom_in  (chany_bottom_in),
      .grid_opin        (grid_opin),
      .top_inpad        (top_inpad),
      .left_inpad       (left_inpad),
      .chanx_right_out  (chanx_right_out),
      .chany_bottom_out (chany_bottom_out),
      .ccff_tail        (ccff_tail),
      .cfg_done         (cfg_done),
      .cfg_err          (cfg_err)
   );

   initial begin
      prog_clk = 1'b0;
      forever #5 prog_clk = ~prog_clk;
   end

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model: m_bits holds the shift register oldest-first, m_bits[0] is the tail bit
   bit m_bits[$];
   int m_count;
   int m_rsel [CHAN_W];
   int m_bsel [CHAN_W];
   bit m_done;
   bit m_err;

   function automatic int src(input int k);
      return (CHAN_W - 2 - k + CHAN_W) % CHAN_W;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      for (int k = 0; k < CFG_BITS; k++) m_bits.push_back(1'b0);
      m_count = 0;
      for (int k = 0; k < CHAN_W; k++) begin
         m_rsel[k] = 0;
         m_bsel[k] = 0;
      end
      m_done = 1'b0;
      m_err  = 1'b0;
   endtask

   task automatic model_step(input logic head, input logic sh, input logic cm, input logic rn);
      if (!rn) begin
         model_reset();
      end else if (cm) begin
         if (m_count == CFG_BITS) begin
            // shift-register index n is m_bits[CFG_BITS-1-n]
            for (int k = 0; k < CHAN_W; k++) m_rsel[k] = 0;
            for (int n = 0; n < CFG_BITS; n++) begin
               if (n < CHAN_W * SEL_R)
                  m_rsel[n / SEL_R] += int'(m_bits[CFG_BITS-1-n]) << (n % SEL_R);
               else
                  m_bsel[n - CHAN_W * SEL_R] = int'(m_bits[CFG_BITS-1-n]);
            end
            m_done = 1'b1;
            m_err  = 1'b0;
         end else begin
            m_done = 1'b0;
            m_err  = 1'b1;
         end
         m_count = 0;
      end else if (sh) begin
         void'(m_bits.pop_front());
         m_bits.push_back(head);
         if (m_count < CNT_SAT) m_count++;
         m_done = 1'b0;
      end
   endtask

   function automatic logic [CHAN_W-1:0] exp_right();
      logic [CHAN_W-1:0] r;
      for (int i = 0; i < CHAN_W; i++) begin
         int s;
         s = m_rsel[i];
         if (s == 0)                   r[i] = chany_bottom_in[src(i)];
         else if (s <= NUM_OPINS)      r[i] = grid_opin[s-1];
         else if (s == NUM_OPINS + 1)  r[i] = top_inpad;
         else                          r[i] = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [CHAN_W-1:0] exp_bottom();
      logic [CHAN_W-1:0] b;
      for (int j = 0; j < CHAN_W; j++)
         b[j] = (m_bsel[j] != 0) ? left_inpad : chanx_right_in[src(j)];
      return b;
   endfunction

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge prog_clk) begin
      if (chk_en) begin
         chk("right_out",  32'(chanx_right_out),  32'(exp_right()));
         chk("bottom_out", 32'(chany_bottom_out), 32'(exp_bottom()));
         chk("ccff_tail",  32'(ccff_tail),        32'(m_bits[0]));
         chk("cfg_done",   32'(cfg_done),         32'(m_done));
         chk("cfg_err",    32'(cfg_err),          32'(m_err));
      end
   end

   task automatic tick(input logic head, input logic sh, input logic cm, input logic rn);
      ccff_head    = head;
      cfg_shift_en = sh;
      cfg_commit   = cm;
      prog_reset_n = rn;
      @(posedge prog_clk);
      model_step(head, sh, cm, rn);
      #1;
      chanx_right_in  = CHAN_W'($urandom);
      chany_bottom_in = CHAN_W'($urandom);
      grid_opin       = NUM_OPINS'($urandom);
      top_inpad       = 1'($urandom);
      left_inpad      = 1'($urandom);
      #1;
   endtask

   task automatic shift_vec(input logic [CFG_BITS-1:0] v, input int nbits);
      for (int k = 0; k < nbits; k++) tick(v[CFG_BITS-1-k], 1'b1, 1'b0, 1'b1);
   endtask

   function automatic logic [CFG_BITS-1:0] rand_vec();
      return {23'($urandom), 32'($urandom)};
   endfunction

   logic [CFG_BITS-1:0] v;
   logic                hist [CFG_BITS];
   logic                tail_before;

   initial begin
      model_reset();
      ccff_head = 0; cfg_shift_en = 0; cfg_commit = 0; prog_reset_n = 0;
      chanx_right_in = '0; chany_bottom_in = '0; grid_opin = '0;
      top_inpad = 0; left_inpad = 0;

      // Reset with shift and commit also asserted: reset must win
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      chk_en = 1'b1;
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);

      // Default routing after reset
      chk("t1_right0",   32'(chanx_right_out[0]),   32'(chany_bottom_in[9]));
      chk("t1_bottom10", 32'(chany_bottom_out[10]), 32'(chanx_right_in[10]));
      chk("t1_done",     32'(cfg_done), 32'd0);
      chk("t1_err",      32'(cfg_err),  32'd0);

      // Right track 0 -> opin 3 (s=4), bottom track 2 -> left inpad
      v = '0;
      v[3:0] = 4'd4;
      v[CHAN_W*SEL_R + 2] = 1'b1;
      shift_vec(v, CFG_BITS);
      chk("t2_pre_right0", 32'(chanx_right_out[0]), 32'(chany_bottom_in[9]));
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      chk("t2_right0",  32'(chanx_right_out[0]),  32'(grid_opin[3]));
      chk("t2_bottom2", 32'(chany_bottom_out[2]), 32'(left_inpad));
      chk("t2_done",    32'(cfg_done), 32'd1);

      // Short load is rejected, then a full load is accepted
      v = rand_vec();
      shift_vec(v, CFG_BITS - 1);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      chk("t3_err",    32'(cfg_err), 32'd1);
      chk("t3_done",   32'(cfg_done), 32'd0);
      chk("t3_right0", 32'(chanx_right_out[0]), 32'(grid_opin[3]));
      shift_vec(v, CFG_BITS);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      chk("t3b_err",  32'(cfg_err), 32'd0);
      chk("t3b_done", 32'(cfg_done), 32'd1);

      // ccff_tail is ccff_head delayed by CFG_BITS shifts
      for (int k = 0; k < CFG_BITS; k++) begin
         hist[k] = 1'($urandom);
         tick(hist[k], 1'b1, 1'b0, 1'b1);
      end
      for (int k = 0; k < CFG_BITS; k++) begin
         chk("t4_tail", 32'(ccff_tail), 32'(hist[k]));
         tick(1'($urandom), 1'b1, 1'b0, 1'b1);
      end

      // Clear the saturated count, then commit while shifting
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      chk("t5_sat_err", 32'(cfg_err), 32'd1);
      shift_vec(rand_vec(), CFG_BITS);
      tail_before = ccff_tail;
      tick(~tail_before, 1'b1, 1'b1, 1'b1);
      chk("t5_done", 32'(cfg_done), 32'd1);
      chk("t5_err",  32'(cfg_err), 32'd0);
      chk("t5_tail", 32'(ccff_tail), 32'(tail_before));

      // Out-of-range select on right track 5, then reset mid-shift
      v = '0;
      v[5*SEL_R +: SEL_R] = 4'd12;
      shift_vec(v, CFG_BITS);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      chk("t6_right5", 32'(chanx_right_out[5]), 32'd0);
      shift_vec(rand_vec() | 55'h1, 20);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_right0",   32'(chanx_right_out[0]),   32'(chany_bottom_in[9]));
      chk("t6_bottom10", 32'(chany_bottom_out[10]), 32'(chanx_right_in[10]));
      chk("t6_done",     32'(cfg_done),  32'd0);
      chk("t6_err",      32'(cfg_err),   32'd0);
      chk("t6_tail",     32'(ccff_tail), 32'd0);

      // Random full loads with idle gaps
      for (int n = 0; n < 8; n++) begin
         v = rand_vec();
         for (int k = 0; k < CFG_BITS; k++) begin
            if ($urandom_range(0, 7) == 0) tick(1'($urandom), 1'b0, 1'b0, 1'b1);
            tick(v[CFG_BITS-1-k], 1'b1, 1'b0, 1'b1);
         end
         tick(1'($urandom), 1'($urandom), 1'b1, 1'b1);
         for (int k = 0; k < 4; k++) tick(1'($urandom), 1'b0, 1'b0, 1'b1);
      end

      // Unconstrained control mix
      for (int n = 0; n < 400; n++)
         tick(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 49) != 0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
